// File: rtl/cordic_vectoring.sv
// Fully pipelined vectoring-mode CORDIC: signed (re, im) -> magnitude and 16-bit phase.
// Accepts one sample per clock with a fixed latency of ITER+2 cycles and no backpressure.
module cordic_vectoring #(
    parameter int ITER = 14,  // legal range 8..14
    parameter int FRAC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic signed [13:0] re_in,
    input  logic signed [13:0] im_in,
    output logic               out_valid,
    output logic        [14:0] mag_out,
    output logic        [15:0] arg_out
);
    localparam int W       = 16 + FRAC;
    localparam int PW      = W + 17;
    localparam int LATENCY = ITER + 2;

    localparam logic [15:0] ATAN [0:13] = '{
        16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163,
        16'd81,   16'd41,   16'd20,   16'd10,   16'd5,   16'd3,   16'd1
    };

    localparam logic signed [PW-1:0] INV_GAIN = PW'(39797);
    localparam logic signed [PW-1:0] ROUND    = PW'(1) <<< (15 + FRAC);
    localparam logic signed [PW-1:0] MAG_MAX  = PW'(32767);

    logic signed [W-1:0] r_x    [0:ITER];
    logic signed [W-1:0] r_y    [0:ITER];
    logic        [15:0]  r_z    [0:ITER];
    logic                r_zero [0:ITER];
    logic [LATENCY-1:0]  r_vld;

    logic signed [W-1:0]  w_re;
    logic signed [W-1:0]  w_im;
    logic                 w_zero;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_scaled;
    logic        [14:0]   w_mag;

    // Two spare sign bits above the input keep the negated -8192 representable.
    assign w_re   = {{(W-14-FRAC){re_in[13]}}, re_in, {FRAC{1'b0}}};
    assign w_im   = {{(W-14-FRAC){im_in[13]}}, im_in, {FRAC{1'b0}}};
    assign w_zero = (re_in == '0) && (im_in == '0);

    // NOTE: the data arrays are reset too, not only r_vld, so every output is 0 straight after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= ITER; i++) begin
                r_x[i]    <= '0;
                r_y[i]    <= '0;
                r_z[i]    <= '0;
                r_zero[i] <= 1'b0;
            end
        end else begin
            // NOTE: non-blocking assignments make each stage read the previous stage's pre-edge value.
            if (re_in[13]) begin
                r_x[0] <= -w_re;
                r_y[0] <= -w_im;
                r_z[0] <= 16'd32768;
            end else begin
                r_x[0] <= w_re;
                r_y[0] <= w_im;
                r_z[0] <= 16'd0;
            end
            r_zero[0] <= w_zero;

            for (int i = 0; i < ITER; i++) begin
                if (r_y[i][W-1]) begin
                    r_x[i+1] <= r_x[i] - (r_y[i] >>> i);
                    r_y[i+1] <= r_y[i] + (r_x[i] >>> i);
                    r_z[i+1] <= r_z[i] - ATAN[i];
                end else begin
                    r_x[i+1] <= r_x[i] + (r_y[i] >>> i);
                    r_y[i+1] <= r_y[i] - (r_x[i] >>> i);
                    r_z[i+1] <= r_z[i] + ATAN[i];
                end
                r_zero[i+1] <= r_zero[i];
            end
        end
    end

    // Gain compensation by 1/K ~= 39797 / 2^16, rounded half-up and saturated.
    assign w_prod   = PW'(r_x[ITER]) * INV_GAIN + ROUND;
    assign w_scaled = w_prod >>> (16 + FRAC);

    // NOTE: w_mag is assigned first on every path so no latch is inferred.
    always_comb begin
        w_mag = w_scaled[14:0];
        if (w_scaled[PW-1]) begin
            w_mag = '0;
        end else if (w_scaled > MAG_MAX) begin
            w_mag = 15'h7FFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= '0;
            mag_out <= '0;
            arg_out <= '0;
        end else begin
            r_vld <= {r_vld[LATENCY-2:0], in_valid};
            if (r_zero[ITER]) begin
                mag_out <= '0;
                arg_out <= '0;
            end else begin
                mag_out <= w_mag;
                arg_out <= r_z[ITER];
            end
        end
    end

    assign out_valid = r_vld[LATENCY-1];

endmodule
